// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter encoding
// and its saturating update rule.
package branch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_state_t;

  localparam bht_state_t BHT_RESET = WNT;

  function automatic bht_state_t bht_next(input bht_state_t state, input logic taken);
    bht_state_t nxt;
    case (state)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = BHT_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Direct-mapped table of 2-bit saturating counters: one combinational read
// port, one synchronous write port, async active-low reset to WNT.
module branch_bht
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_state_t       rd_state,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_state_t r_bht [BHT_ENTRIES];

  // Read is from the registered array, so a same-cycle write is not bypassed.
  assign rd_state = r_bht[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= BHT_RESET;
      end
    end else if (wr_en) begin
      r_bht[wr_idx] <= bht_next(r_bht[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch prediction and redirect controller: BHT lookup in ID, resolution in EX,
// redirect/flush priority. Optional perf counters under `BRANCH_PERF_EN.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        id_valid,
  input  logic        id_is_branch,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_target,
  output logic        id_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic        br_taken,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [31:0] perf_br_cnt,
  output logic [31:0] perf_mis_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0] w_id_idx;
  logic [IDX_W-1:0] w_ex_idx;
  bht_state_t       w_id_state;
  logic             w_ex_res;
  logic             w_mispred;
  logic             w_unused_pc_bits;

  assign w_id_idx = id_pc[IDX_W+1:2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_unused_pc_bits = ^{id_pc[31:IDX_W+2], id_pc[1:0]};

  // Gating with rst_n keeps every redirect output low while reset is held.
  assign w_ex_res  = rst_n & ex_valid & ex_is_branch & ~stall;
  assign w_mispred = w_ex_res & (br_taken ^ ex_pred_taken);

  branch_bht #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (w_id_idx),
    .rd_state (w_id_state),
    .wr_en    (w_ex_res),
    .wr_idx   (w_ex_idx),
    .wr_taken (br_taken)
  );

  assign id_pred_taken = id_valid & id_is_branch & ~stall & (w_id_state inside {WT, ST});

  // An EX mispredict outranks an ID predict-taken: the ID instruction is wrong-path.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    if (w_mispred) begin
      redirect    = 1'b1;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      redirect_pc = br_taken ? ex_target : (ex_pc + 32'd4);
    end else if (id_pred_taken && rst_n) begin
      redirect    = 1'b1;
      flush_ifid  = 1'b1;
      redirect_pc = id_target;
    end
  end

`ifdef BRANCH_PERF_EN
  logic [31:0] r_br_cnt;
  logic [31:0] r_mis_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt  <= 32'h0;
      r_mis_cnt <= 32'h0;
    end else begin
      if (w_ex_res)  r_br_cnt  <= r_br_cnt + 32'd1;
      if (w_mispred) r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign perf_br_cnt  = r_br_cnt;
  assign perf_mis_cnt = r_mis_cnt;
`else
  assign perf_br_cnt  = 32'h0;
  assign perf_mis_cnt = 32'h0;
`endif

endmodule
